// File: rtl/spi_master.sv
// Memory-mapped SPI master (mode 0, MSB first, 8-bit frames) with software chip select.
// Registers: 0x00 DATA, 0x04 CTRL {CS, DIV[7:0]}, 0x08 STATUS {RXV, BUSY}.
module spi_master #(
   parameter logic [7:0] DEFAULT_DIV = 8'd3,
   parameter logic       DEFAULT_CS  = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] spi_address,
   input  logic [31:0] spi_wdata,
   input  logic [3:0]  spi_wsel,
   input  logic        spi_valid,
   output logic [31:0] spi_rdata,
   output logic        spi_ready,
   output logic        spi_error,
   output logic        spi_sclk,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        spi_cs_n
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   state_t     state;
   logic [7:0] div;
   logic [7:0] cnt;
   logic [7:0] tx_sh;
   logic [7:0] rx_sh;
   logic [7:0] rx_data;
   logic [2:0] bit_cnt;
   logic       cs;
   logic       rxv;
   logic       miso_s1;
   logic       miso_s2;

   logic busy;
   logic accept;
   logic is_write;
   logic sel_data;
   logic sel_ctrl;
   logic sel_stat;
   logic bad_req;
   logic start;
   logic data_rd;
   logic unused_bits;

   // Handshake: the switch holds spi_valid until it sees a one-cycle ready or
   // error pulse; a request is taken only while no response is being shown.
   assign accept   = spi_valid && !spi_ready && !spi_error;
   assign is_write = |spi_wsel;
   assign sel_data = (spi_address[7:2] == 6'd0);
   assign sel_ctrl = (spi_address[7:2] == 6'd1);
   assign sel_stat = (spi_address[7:2] == 6'd2);
   assign busy     = (state != IDLE);
   assign bad_req  = !(sel_data || sel_ctrl || sel_stat) || (sel_data && spi_wsel[0] && busy);
   assign start    = accept && !bad_req && sel_data && spi_wsel[0];
   assign data_rd  = accept && !bad_req && sel_data && !is_write;
   assign spi_cs_n = ~cs;

   assign unused_bits = ^{spi_address[31:8], spi_address[1:0], spi_wdata[31:9]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         miso_s1 <= 1'b0;
         miso_s2 <= 1'b0;
      end else begin
         miso_s1 <= spi_miso;
         miso_s2 <= miso_s1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         spi_ready <= 1'b0;
         spi_error <= 1'b0;
         spi_rdata <= 32'h0;
         spi_sclk  <= 1'b0;
         spi_mosi  <= 1'b0;
         div       <= DEFAULT_DIV;
         cs        <= DEFAULT_CS;
         cnt       <= 8'h0;
         tx_sh     <= 8'h0;
         rx_sh     <= 8'h0;
         rx_data   <= 8'h0;
         bit_cnt   <= 3'd0;
         rxv       <= 1'b0;
      end else begin
         spi_ready <= 1'b0;
         spi_error <= 1'b0;
         if (accept) begin
            spi_rdata <= 32'h0;
            if (bad_req) begin
               spi_error <= 1'b1;
            end else begin
               spi_ready <= 1'b1;
               if (!is_write) begin
                  if (sel_data)
                     spi_rdata <= {24'h0, rx_data};
                  else if (sel_ctrl)
                     spi_rdata <= {23'h0, cs, div};
                  else
                     spi_rdata <= {30'h0, rxv, busy};
               end else if (sel_ctrl) begin
                  if (spi_wsel[0]) div <= spi_wdata[7:0];
                  if (spi_wsel[1]) cs  <= spi_wdata[8];
               end
            end
         end

         // Cleared here so that a completing transfer in DONE below overrides it.
         if (data_rd) rxv <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  tx_sh    <= spi_wdata[7:0];
                  spi_mosi <= spi_wdata[7];
                  rxv      <= 1'b0;
                  cnt      <= div;
                  bit_cnt  <= 3'd0;
                  state    <= LOW;
               end
            end
            LOW: begin
               if (cnt == 8'h0) begin
                  spi_sclk <= 1'b1;
                  rx_sh    <= {rx_sh[6:0], miso_s2};
                  cnt      <= div;
                  state    <= HIGH;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            HIGH: begin
               if (cnt == 8'h0) begin
                  spi_sclk <= 1'b0;
                  cnt      <= div;
                  if (bit_cnt == 3'd7) begin
                     state <= DONE;
                  end else begin
                     tx_sh    <= {tx_sh[6:0], 1'b0};
                     spi_mosi <= tx_sh[6];
                     bit_cnt  <= bit_cnt + 3'd1;
                     state    <= LOW;
                  end
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            DONE: begin
               rx_data <= rx_sh;
               rxv     <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Memory-mapped SPI master (mode 0, MSB first, 8-bit frames): an additional slave on the SoC bus switch, beside the bootrom, RAM, timer and UART.
- Decoded at base 32'h2002_0000 with an 8-bit address window.
- The CPU writes a byte to start a transfer, polls STATUS, then reads the received byte.
- Chip select is software-controlled, so multi-byte flash and SD transactions are possible.

Parameters:
- DEFAULT_DIV, 8'd3: reset value of CTRL.DIV. SCLK half-period is (DIV+1) clk cycles.
- DEFAULT_CS, 1'b0: reset value of CTRL.CS (0 = deasserted).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- spi_address  in  32  bus address; only bits [7:2] decoded
- spi_wdata  in  32  bus write data
- spi_wsel  in  4  byte write enables; 4'b0000 = read
- spi_valid  in  1  request from bus switch, held until ready
- spi_rdata  out  32  read data, valid with ready
- spi_ready  out  1  single-cycle completion pulse
- spi_error  out  1  single-cycle error pulse (replaces ready)
- spi_sclk  out  1  SPI clock, idle low
- spi_mosi  out  1  SPI data out
- spi_miso  in  1  SPI data in; double-flopped internally
- spi_cs_n  out  1  chip select, active low

Behaviour:
- Reset (rst=0, async):
  - spi_ready=0, spi_error=0, spi_rdata=0
  - spi_sclk=0, spi_mosi=0, spi_cs_n=~DEFAULT_CS
  - FSM=IDLE, RXDATA=0, RXV=0, CTRL={DEFAULT_CS,DEFAULT_DIV}
  - Reset mid-transfer aborts immediately; no partial byte is kept.
- Register map (offset = address[7:0]):
  - 0x00 DATA. Write: byte wdata[7:0] starts a transfer (needs wsel[0]). Read: {24'h0, RXDATA}; clears RXV.
  - 0x04 CTRL: [7:0]=DIV, [8]=CS. R/W with byte-lane wsel.
  - 0x08 STATUS, read-only: [0]=BUSY, [1]=RXV. Writes are ignored and acked.
  - Any other offset: error.
- Bus handshake:
  - Accept when spi_valid && !spi_ready && !spi_error.
  - Response is registered one cycle after accept: ready or error high for exactly 1 cycle, then low.
  - Back-to-back requests therefore complete every 2 cycles.
  - spi_rdata is updated with the response. It is 0 on writes and errors.
- Error cases:
  - Unmapped offset.
  - Write to DATA while BUSY=1. The write is dropped and the transfer in flight is undisturbed.
- CTRL.DIV written while BUSY takes effect at the next half-period reload. CS change is immediate: spi_cs_n = ~CTRL.CS.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE → LOW on a DATA write:
    - load TX shift register
    - drive spi_mosi = bit7
    - BUSY=1, RXV=0
    - half-period counter = DIV, bit count = 0
  - LOW (sclk=0): counter decrements. At 0 → HIGH: sclk=1, sample synced MISO into shift LSB, reload counter.
  - HIGH (sclk=1): at counter 0:
    - if bit count = 7 → DONE, sclk=0
    - else sclk=0, shift TX left, mosi = next bit, bit count +1, → LOW.
  - DONE (1 cycle): RXDATA ← shift register, RXV=1, BUSY=0 → IDLE.
- Total transfer = 16*(DIV+1)+2 clk cycles from DATA write acceptance to BUSY=0.
- DIV=0 is legal: SCLK = clk/2.
- A DATA read in the same cycle DONE sets RXV: the set wins (RXV=1 after). The read returns the old RXDATA.
- spi_mosi holds its last bit in IDLE.

Test Plan:
- Reset then read 0x04 → 32'h0000_0003. Read 0x08 → 0. Check spi_cs_n=1, sclk=0.
- Write 0x04=32'h103, write 0x00=32'hA5, MISO loopback from MOSI:
  - 8 SCLK pulses, each high 4 clk
  - MOSI sequence 1,0,1,0,0,1,0,1
  - BUSY for 66 cycles
  - then read 0x00 → 32'hA5, STATUS → 0
- MISO tied 1 with DIV=0, write 0x00=32'h3C → RXDATA=8'hFF, transfer 18 cycles, SCLK = clk/2.
- Write 0x00 while BUSY → spi_error pulse 1 cycle, no ready. The transfer in progress completes with the original byte.
- Read 0x0C and 0xFC → error pulse each, rdata=0. Hold valid for 5 cycles → ready/error alternates with a 2-cycle cadence, never 2 consecutive cycles.
- Assert rst mid-transfer (after 3 SCLK edges) → outputs return to reset values within the same cycle. After release, STATUS=0 and RXDATA=0.
